dht22_sevenseg_display: RTL and testbench

//  Consumes 40-bit frames from the DHT22 reader and displays them on the Nexys4 8-digit seven-segment display.

---
 rtl/dht22_sevenseg_display.sv | 184 ++++++++++++++++++
 tb/tb_dht22_sevenseg_display.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht22_sevenseg_display.sv
// DHT22 frame to Nexys4 8-digit seven-segment display: checksum check, double-dabble
// conversion of humidity and temperature, and a time-multiplexed digit scan.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | ready for a frame, latches it on accept
//   CHECK   | verify checksum, seed humidity conversion
//   CONV_H  | 14 double-dabble steps on clamped humidity
//   CONV_T  | 14 double-dabble steps on clamped temperature
//   LOAD    | write all eight digit registers, clear err_led
module dht22_sevenseg_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [39:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        err_led,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [7:0]  AN
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_CONV_H = 3'd2;
  localparam logic [2:0] ST_CONV_T = 3'd3;
  localparam logic [2:0] ST_LOAD   = 3'd4;

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  // Decimal point sits after H1 (AN5) and T1 (AN1)
  localparam logic [7:0] DP_PATTERN = 8'b1101_1101;

  logic [2:0]  state;
  logic [39:0] frame_q;
  logic [29:0] shreg;
  logic [29:0] step;
  logic [3:0]  step_cnt;
  logic [15:0] hum_bcd;
  logic [11:0] temp_bcd;
  logic [7:0]  sum;
  logic [13:0] hum_clamped;
  logic [13:0] temp_clamped;

  logic [6:0]  digit_seg [8];
  logic [7:0]  digit_dp;
  logic [6:0]  new_seg [8];

  logic [PW-1:0] prescaler;
  logic [2:0]    scan_idx;
  logic [2:0]    scan_next;
  logic          scan_tc;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble step on {bcd[15:0], bin[13:0]}: add-3 correction then shift
  function automatic logic [29:0] dabble_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[14+4*i +: 4] >= 4'd5)
        t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  assign step         = dabble_step(shreg);
  assign sum          = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  assign hum_clamped  = (frame_q[39:24] > 16'd9999) ? 14'd9999 : frame_q[37:24];
  assign temp_clamped = (frame_q[22:8] > 15'd999) ? 14'd999 : {4'd0, frame_q[17:8]};
  assign frame_ready  = (state == ST_IDLE);

  always_comb begin
    new_seg[7] = (hum_bcd[15:12] == 4'd0) ? SEG_BLANK : seg_of(hum_bcd[15:12]);
    new_seg[6] = seg_of(hum_bcd[11:8]);
    new_seg[5] = seg_of(hum_bcd[7:4]);
    new_seg[4] = seg_of(hum_bcd[3:0]);
    new_seg[3] = frame_q[23] ? SEG_DASH : SEG_BLANK;
    new_seg[2] = (temp_bcd[11:8] == 4'd0) ? SEG_BLANK : seg_of(temp_bcd[11:8]);
    new_seg[1] = seg_of(temp_bcd[7:4]);
    new_seg[0] = seg_of(temp_bcd[3:0]);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= ST_IDLE;
      frame_q  <= '0;
      shreg    <= '0;
      step_cnt <= '0;
      hum_bcd  <= '0;
      temp_bcd <= '0;
      err_led  <= 1'b0;
      digit_dp <= 8'hFF;
      for (int i = 0; i < 8; i++) digit_seg[i] <= SEG_DASH;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_valid) begin
            frame_q <= frame_data;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (sum != frame_q[7:0]) begin
            err_led <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            shreg    <= {16'd0, hum_clamped};
            step_cnt <= 4'd13;
            state    <= ST_CONV_H;
          end
        end
        ST_CONV_H: begin
          shreg <= step;
          if (step_cnt == 4'd0) begin
            hum_bcd  <= step[29:14];
            shreg    <= {16'd0, temp_clamped};
            step_cnt <= 4'd13;
            state    <= ST_CONV_T;
          end else begin
            step_cnt <= step_cnt - 4'd1;
          end
        end
        ST_CONV_T: begin
          shreg <= step;
          if (step_cnt == 4'd0) begin
            temp_bcd <= step[25:14];
            state    <= ST_LOAD;
          end else begin
            step_cnt <= step_cnt - 4'd1;
          end
        end
        ST_LOAD: begin
          for (int i = 0; i < 8; i++) digit_seg[i] <= new_seg[i];
          digit_dp <= DP_PATTERN;
          err_led  <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // SEG/DP are looked up with the next scan index so they switch together with AN
  assign scan_tc   = (prescaler == PW'(REFRESH_DIV - 1));
  assign scan_next = scan_tc ? scan_idx + 3'd1 : scan_idx;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      prescaler <= '0;
      scan_idx  <= 3'd0;
      AN        <= 8'hFE;
      SEG       <= SEG_DASH;
      DP        <= 1'b1;
    end else begin
      prescaler <= scan_tc ? '0 : prescaler + 1'b1;
      scan_idx  <= scan_next;
      AN        <= ~(8'd1 << scan_next);
      SEG       <= digit_seg[scan_next];
      DP        <= digit_dp[scan_next];
    end
  end

endmodule

// File: tb/tb_dht22_sevenseg_display.sv
// Directed bench for dht22_sevenseg_display: scan, conversion, checksum, busy and reset cases.
module tb_dht22_sevenseg_display;

  localparam int RDIV = 4;

  // {DP, SEG} per digit index 0..7 (AN0..AN7)
  localparam logic [7:0] EXP_A [8] = '{8'hF9, 8'h30, 8'hA4, 8'hFF, 8'hB0, 8'h12, 8'h92, 8'hFF};
  localparam logic [7:0] EXP_B [8] = '{8'hF9, 8'h40, 8'hF9, 8'hBF, 8'hC0, 8'h40, 8'hC0, 8'hF9};
  localparam logic [7:0] EXP_C [8] = '{8'h90, 8'h10, 8'h90, 8'hFF, 8'h90, 8'h10, 8'h90, 8'h90};
  localparam logic [7:0] EXP_D [8] = '{8'hC0, 8'h40, 8'hFF, 8'hBF, 8'hC0, 8'h40, 8'hF9, 8'hFF};

  localparam logic [39:0] FRAME_A   = 40'h022900E712;
  localparam logic [39:0] FRAME_B   = 40'h03E88065D0;
  localparam logic [39:0] FRAME_BAD = 40'h022900E713;
  localparam logic [39:0] FRAME_X   = 40'h0100000001;
  localparam logic [39:0] FRAME_C   = 40'h271003E822;
  localparam logic [39:0] FRAME_D   = 40'h00648000E4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] frame_data = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic        err_led;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] obs [8];
  logic [7:0] seen;

  dht22_sevenseg_display #(.REFRESH_DIV(RDIV)) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .err_led     (err_led),
    .SEG         (seg),
    .DP          (dp),
    .AN          (an)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic send_frame(input logic [39:0] d);
    @(negedge clk);
    frame_data  = d;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  // Records {DP,SEG} for each digit over more than one full scan
  task automatic capture_display();
    seen = '0;
    for (int i = 0; i < 8; i++) obs[i] = 8'h00;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (an[i] == 1'b0) begin
          obs[i]  = {dp, seg};
          seen[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if ({frame_ready, err_led, dp, an, seg} !== {1'b1, 1'b0, 1'b1, 8'hFE, 7'h3F})
      $display("FAIL reset_outputs: got ready=%b err=%b dp=%b an=%h seg=%h expected 1 0 1 fe 3f",
               frame_ready, err_led, dp, an, seg);
    else pass_cnt++;
  endtask

  task automatic test_scan();
    logic [7:0] exp_an;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      exp_an = ~(8'd1 << ((k / RDIV) % 8));
      total_cnt++;
      if (an !== exp_an || seg !== 7'h3F)
        $display("FAIL scan cycle %0d: got an=%h seg=%h expected an=%h seg=3f", k, an, seg, exp_an);
      else pass_cnt++;
    end
  endtask

  task automatic test_frame_a();
    int idx;
    send_frame(FRAME_A);
    total_cnt++;
    if (frame_ready !== 1'b0) $display("FAIL frame_a ready_after_accept: got %b expected 0", frame_ready);
    else pass_cnt++;
    repeat (29) @(negedge clk);
    total_cnt++;
    if (frame_ready !== 1'b0 || seg !== 7'h3F)
      $display("FAIL frame_a edge29: got ready=%b seg=%h expected ready=0 seg=3f", frame_ready, seg);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (seg !== 7'h3F || dp !== 1'b1)
      $display("FAIL frame_a edge30: got seg=%h dp=%b expected seg=3f dp=1", seg, dp);
    else pass_cnt++;
    @(negedge clk);
    idx = 0;
    for (int i = 0; i < 8; i++) if (an[i] == 1'b0) idx = i;
    total_cnt++;
    if (frame_ready !== 1'b1 || err_led !== 1'b0 || {dp, seg} !== EXP_A[idx])
      $display("FAIL frame_a edge31: got ready=%b err=%b digit%0d=%h expected ready=1 err=0 digit=%h",
               frame_ready, err_led, idx, {dp, seg}, EXP_A[idx]);
    else pass_cnt++;
    capture_display();
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (seen[i] !== 1'b1 || obs[i] !== EXP_A[i])
        $display("FAIL frame_a digit %0d: got %h expected %h", i, obs[i], EXP_A[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_frame_b();
    send_frame(FRAME_B);
    repeat (31) @(negedge clk);
    total_cnt++;
    if (frame_ready !== 1'b1 || err_led !== 1'b0)
      $display("FAIL frame_b status: got ready=%b err=%b expected 1 0", frame_ready, err_led);
    else pass_cnt++;
    capture_display();
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (seen[i] !== 1'b1 || obs[i] !== EXP_B[i])
        $display("FAIL frame_b digit %0d: got %h expected %h", i, obs[i], EXP_B[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_bad_checksum();
    send_frame(FRAME_BAD);
    total_cnt++;
    if (err_led !== 1'b0) $display("FAIL bad_cs err_at_accept: got %b expected 0", err_led);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (err_led !== 1'b1 || frame_ready !== 1'b1)
      $display("FAIL bad_cs err_set: got err=%b ready=%b expected 1 1", err_led, frame_ready);
    else pass_cnt++;
    capture_display();
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (seen[i] !== 1'b1 || obs[i] !== EXP_B[i])
        $display("FAIL bad_cs hold digit %0d: got %h expected %h", i, obs[i], EXP_B[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (err_led !== 1'b1) $display("FAIL bad_cs sticky: got %b expected 1", err_led);
    else pass_cnt++;
    send_frame(FRAME_A);
    repeat (29) @(negedge clk);
    total_cnt++;
    if (err_led !== 1'b1) $display("FAIL bad_cs err_before_load: got %b expected 1", err_led);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (err_led !== 1'b0) $display("FAIL bad_cs err_cleared: got %b expected 0", err_led);
    else pass_cnt++;
    capture_display();
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (seen[i] !== 1'b1 || obs[i] !== EXP_A[i])
        $display("FAIL bad_cs recover digit %0d: got %h expected %h", i, obs[i], EXP_A[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignore();
    send_frame(FRAME_B);
    repeat (4) @(negedge clk);
    frame_data  = FRAME_X;
    frame_valid = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (frame_ready !== 1'b0) $display("FAIL busy ready_during_pulse: got %b expected 0", frame_ready);
    else pass_cnt++;
    frame_valid = 1'b0;
    repeat (26) @(negedge clk);
    total_cnt++;
    if (frame_ready !== 1'b1) $display("FAIL busy ready_after_load: got %b expected 1", frame_ready);
    else pass_cnt++;
    repeat (40) @(negedge clk);
    total_cnt++;
    if (frame_ready !== 1'b1) $display("FAIL busy no_requeue: got ready=%b expected 1", frame_ready);
    else pass_cnt++;
    capture_display();
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (seen[i] !== 1'b1 || obs[i] !== EXP_B[i])
        $display("FAIL busy digit %0d: got %h expected %h", i, obs[i], EXP_B[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_clamp_sign();
    send_frame(FRAME_C);
    repeat (31) @(negedge clk);
    capture_display();
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (seen[i] !== 1'b1 || obs[i] !== EXP_C[i])
        $display("FAIL clamp digit %0d: got %h expected %h", i, obs[i], EXP_C[i]);
      else pass_cnt++;
    end
    send_frame(FRAME_D);
    repeat (31) @(negedge clk);
    capture_display();
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (seen[i] !== 1'b1 || obs[i] !== EXP_D[i])
        $display("FAIL neg_zero digit %0d: got %h expected %h", i, obs[i], EXP_D[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_conv();
    send_frame(FRAME_BAD);
    repeat (2) @(negedge clk);
    send_frame(FRAME_A);
    repeat (20) @(negedge clk);
    total_cnt++;
    if (frame_ready !== 1'b0 || err_led !== 1'b1)
      $display("FAIL mid_reset pre: got ready=%b err=%b expected 0 1", frame_ready, err_led);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({frame_ready, err_led, dp, an, seg} !== {1'b1, 1'b0, 1'b1, 8'hFE, 7'h3F})
      $display("FAIL mid_reset async: got ready=%b err=%b dp=%b an=%h seg=%h expected 1 0 1 fe 3f",
               frame_ready, err_led, dp, an, seg);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    capture_display();
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (seen[i] !== 1'b1 || obs[i] !== 8'hBF)
        $display("FAIL mid_reset digit %0d: got %h expected bf", i, obs[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (frame_ready !== 1'b1) $display("FAIL mid_reset ready: got %b expected 1", frame_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_a();
    test_frame_b();
    test_bad_checksum();
    test_busy_ignore();
    test_clamp_sign();
    test_reset_mid_conv();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
